// File: rtl/lsu_access_sequencer.sv
// Load/store access sequencer: turns one core load/store into one or two aligned
// memory beats and returns the reassembled, extended load data.
module lsu_access_sequencer #(
  parameter int XLEN             = 64,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_f3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rdata
);
  localparam int BB   = XLEN / 8;
  localparam int OFFW = $clog2(BB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t state, state_nxt;
  logic   live;
  logic   accept;

  logic [OFFW-1:0]   off_in;
  logic [3:0]        size_in;
  logic [BB-1:0]     smask;
  logic [2*BB-1:0]   mask_in;
  logic [2*XLEN-1:0] wide_in;
  logic              split_in, mis_in, err_in;
  logic [XLEN-1:0]   addr_al_in;

  logic              we_p0, split_p0, err_p0;
  logic [2:0]        f3_p0;
  logic [OFFW-1:0]   off_p0;
  logic [2*BB-1:0]   mask_p0;
  logic [2*XLEN-1:0] wide_p0;
  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   rdata0_p1, rdata1_p1;
  logic [XLEN-1:0]   load_word, load_data;

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input logic [2:0] f3);
    logic [XLEN-1:0] r;
    int              nb;
    logic            s;
    nb = 8 << f3[1:0];
    if (nb > XLEN) nb = XLEN;
    s = 1'b0;
    for (int i = 0; i < XLEN; i++)
      if (i == nb - 1) s = d[i] & ~f3[2];
    for (int i = 0; i < XLEN; i++)
      r[i] = (i < nb) ? d[i] : s;
    return r;
  endfunction

  always_comb begin
    off_in  = req_addr[OFFW-1:0];
    size_in = 4'd1 << req_f3[1:0];
    for (int i = 0; i < BB; i++) smask[i] = (4'(i) < size_in);
    mask_in    = {{BB{1'b0}}, smask} << off_in;
    wide_in    = {{XLEN{1'b0}}, req_wdata} << {off_in, 3'b000};
    split_in   = (int'(off_in) + int'(size_in)) > BB;
    mis_in     = |(off_in & OFFW'(size_in - 4'd1));
    err_in     = (req_f3 == 3'b111) || (req_we && req_f3[2]) ||
                 ((XLEN == 32) && (req_f3 == 3'b011 || req_f3 == 3'b110)) ||
                 (!ALLOW_MISALIGNED && mis_in);
    addr_al_in = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  assign accept = (state == IDLE) && live && req_valid;

  // live holds req_ready low until the first clock edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // request capture and returned beat data
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= req_we;
      f3_p0     <= req_f3;
      off_p0    <= off_in;
      mask_p0   <= mask_in;
      wide_p0   <= wide_in;
      addr_p0   <= addr_al_in;
      split_p0  <= split_in;
      err_p0    <= err_in;
      rdata1_p1 <= '0;
    end
    if (state == WAIT0 && mem_rsp_valid) rdata0_p1 <= mem_rdata;
    if (state == WAIT1 && mem_rsp_valid) rdata1_p1 <= mem_rdata;
  end

  assign load_word = XLEN'({rdata1_p1, rdata0_p1} >> {off_p0, 3'b000});
  assign load_data = extend_load(load_word, f3_p0);

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    unique case (state)
      IDLE: begin
        req_ready = live;
        if (accept) state_nxt = err_in ? RESP : REQ0;
      end
      REQ0: begin
        mem_req_valid = 1'b1;
        mem_we        = we_p0;
        mem_addr      = addr_p0;
        mem_be        = mask_p0[BB-1:0];
        mem_wdata     = wide_p0[XLEN-1:0];
        if (mem_req_ready) state_nxt = WAIT0;
      end
      WAIT0: if (mem_rsp_valid) state_nxt = split_p0 ? REQ1 : RESP;
      REQ1: begin
        mem_req_valid = 1'b1;
        mem_we        = we_p0;
        mem_addr      = addr_p0 + XLEN'(BB);
        mem_be        = mask_p0[2*BB-1:BB];
        mem_wdata     = wide_p0[2*XLEN-1:XLEN];
        if (mem_req_ready) state_nxt = WAIT1;
      end
      WAIT1: if (mem_rsp_valid) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_p0;
        rsp_rdata = (we_p0 || err_p0) ? '0 : load_data;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
